// File: rtl/fir_coeff_loader.sv
// Packs a DW-bit coefficient stream into rows and writes each row as 32-bit words.
// Optional running checksum of accepted beats: FIR_COEFF_LOADER_CHECKSUM_EN.
module fir_coeff_loader #(
    parameter int DW       = 16,
    parameter int SECTIONS = 4,
    parameter int N        = 8,
    parameter int ADDRW    = 8
) (
    input  logic             sys_clk,
    input  logic             reset_n,
    input  logic             ce,
    input  logic             start_i,
    input  logic [DW-1:0]    tdata_s_i,
    input  logic             tvalid_s_i,
    output logic             tready_s_o,
    input  logic             tlast_s_i,
    output logic [ADDRW-1:0] coeff_addr,
    output logic [31:0]      coeff_wdata,
    output logic             coeff_wr,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [15:0]      checksum_o
);

    localparam int RW  = DW * SECTIONS;
    localparam int W   = (RW <= 32) ? 1 : (RW <= 64) ? 2 : 4;
    localparam int PW  = W * 32;
    localparam int RCW = (N > 1) ? $clog2(N) : 1;
    localparam int BCW = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
    localparam int WCW = (W > 1) ? $clog2(W) : 1;

    localparam logic [RCW-1:0] ROW_LAST  = RCW'(N - 1);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(SECTIONS - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e         state_q, state_d;
    logic [RCW-1:0] row_q, row_d;
    logic [BCW-1:0] beat_q, beat_d;
    logic [WCW-1:0] word_q, word_d;
    logic [RW-1:0]  buf_q, buf_d;
    logic           err_q, err_d;
    logic           beat_fire;
    logic           final_beat;
    logic [PW-1:0]  padded;

    assign final_beat = (row_q == ROW_LAST) && (beat_q == BEAT_LAST);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        beat_d     = beat_q;
        word_d     = word_q;
        buf_d      = buf_q;
        err_d      = err_q;
        tready_s_o = 1'b0;
        coeff_wr   = 1'b0;
        done_o     = 1'b0;
        beat_fire  = 1'b0;
        if (ce) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_COLLECT;
                        row_d   = '0;
                        beat_d  = '0;
                        word_d  = '0;
                        buf_d   = '0;
                        err_d   = 1'b0;
                    end
                end
                S_COLLECT: begin
                    tready_s_o = 1'b1;
                    if (tvalid_s_i) begin
                        beat_fire = 1'b1;
                        buf_d[beat_q*DW +: DW] = tdata_s_i;
                        // early tlast drops the partial row, even a full one
                        if (tlast_s_i && !final_beat) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else if (beat_q == BEAT_LAST) begin
                            beat_d  = '0;
                            state_d = S_WRITE;
                            if (final_beat && !tlast_s_i) begin
                                err_d = 1'b1;
                            end
                        end else begin
                            beat_d = beat_q + BCW'(1);
                        end
                    end
                end
                S_WRITE: begin
                    coeff_wr = 1'b1;
                    if (word_q == WORD_LAST) begin
                        word_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            row_d   = row_q + RCW'(1);
                            state_d = S_COLLECT;
                        end
                    end else begin
                        word_d = word_q + WCW'(1);
                    end
                end
                S_DONE: begin
                    done_o  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            beat_q  <= '0;
            word_q  <= '0;
            buf_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            beat_q  <= beat_d;
            word_q  <= word_d;
            buf_q   <= buf_d;
            err_q   <= err_d;
        end
    end

    assign padded      = PW'(buf_q);
    assign coeff_wdata = padded[word_q*32 +: 32];
    assign coeff_addr  = ADDRW'(row_q) * ADDRW'(W) + ADDRW'(word_q);
    assign busy_o      = (state_q != S_IDLE);
    assign error_o     = err_q;

`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (ce && state_q == S_IDLE && start_i) begin
            csum_d = '0;
        end else if (beat_fire) begin
            csum_d = csum_q + 16'(tdata_s_i);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum_o = csum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Bench for fir_coeff_loader: directed and randomized loads against a row-packing model.
module tb_fir_coeff_loader;

    localparam int DW    = 16;
    localparam int S     = 4;
    localparam int N     = 8;
    localparam int ADDRW = 8;
    localparam int W     = 2;
    localparam int NC    = N * S;

    logic             sys_clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             ce = 1'b1;
    logic             start_i = 1'b0;
    logic [DW-1:0]    tdata = '0;
    logic             tvalid = 1'b0;
    logic             tready_s_o;
    logic             tlast = 1'b0;
    logic [ADDRW-1:0] coeff_addr;
    logic [31:0]      coeff_wdata;
    logic             coeff_wr;
    logic             busy_o;
    logic             done_o;
    logic             error_o;
    logic [15:0]      checksum_o;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int ce_viol = 0;

    logic [DW-1:0] coef [NC];
    logic [39:0]   wr_q [$];
    logic [39:0]   exp_q [$];

    always #5 sys_clk = ~sys_clk;

    fir_coeff_loader #(
        .DW(DW), .SECTIONS(S), .N(N), .ADDRW(ADDRW)
    ) dut (
        .sys_clk    (sys_clk),
        .reset_n    (reset_n),
        .ce         (ce),
        .start_i    (start_i),
        .tdata_s_i  (tdata),
        .tvalid_s_i (tvalid),
        .tready_s_o (tready_s_o),
        .tlast_s_i  (tlast),
        .coeff_addr (coeff_addr),
        .coeff_wdata(coeff_wdata),
        .coeff_wr   (coeff_wr),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .checksum_o (checksum_o)
    );

    always @(negedge sys_clk) begin
        if (coeff_wr) wr_q.push_back({coeff_addr, coeff_wdata});
        if (done_o) done_cnt++;
        if (coeff_wr && !ce) ce_viol++;
    end

    // Model: the first `rows` rows, each split into W little-endian 32-bit words.
    function automatic void build_expected(input int rows);
        logic [127:0] rowv;
        exp_q.delete();
        for (int r = 0; r < rows; r++) begin
            rowv = '0;
            for (int s = 0; s < S; s++)
                rowv = rowv | (128'(coef[r*S+s]) << (DW*s));
            for (int k = 0; k < W; k++)
                exp_q.push_back({8'(r*W+k), rowv[32*k +: 32]});
        end
    endfunction

    function automatic logic [15:0] exp_sum(input int n);
        logic [31:0] acc;
        acc = 0;
        for (int i = 0; i < n; i++) acc = acc + 32'(coef[i]);
`ifdef FIR_COEFF_LOADER_CHECKSUM_EN
        return acc[15:0];
`else
        return 16'(acc & 32'h0);
`endif
    endfunction

    task automatic run_load(input int nbeats, input int last_idx,
                            input int vmode, input bit stall,
                            input int spulse, output bit tmo);
        int idx;
        int guard;
        bit tog;
        bit stalled;
        bit acc;
        idx = 0; guard = 0; tog = 1'b1; stalled = 1'b0; tmo = 1'b0;
        start_i = 1'b1;
        @(posedge sys_clk); #1;
        start_i = 1'b0;
        while (idx < nbeats && guard < 2000) begin
            guard++;
            if (stall && !stalled && coeff_wr && wr_q.size() >= 6) begin
                ce = 1'b0;
                tvalid = 1'b0;
                repeat (3) @(posedge sys_clk);
                #1;
                ce = 1'b1;
                stalled = 1'b1;
            end
            tvalid = (vmode == 0) ? 1'b1 :
                     (vmode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            tdata = coef[idx];
            tlast = (idx == last_idx);
            start_i = (idx == spulse);
            @(negedge sys_clk);
            acc = tvalid && tready_s_o && ce;
            @(posedge sys_clk); #1;
            if (acc) idx++;
        end
        tvalid = 1'b0; tlast = 1'b0; start_i = 1'b0;
        if (guard >= 2000) tmo = 1'b1;
    endtask

    task automatic wait_done(input int base, output bit tmo);
        int i;
        i = 0;
        while (done_cnt == base && i < 300) begin
            @(posedge sys_clk); #1;
            i++;
        end
        tmo = (done_cnt == base);
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        checks++;
        if ({tready_s_o, coeff_addr, coeff_wdata, coeff_wr, busy_o,
             done_o, error_o, checksum_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got addr=%h data=%h wr=%b busy=%b done=%b err=%b rdy=%b sum=%h want all zero",
                     coeff_addr, coeff_wdata, coeff_wr, busy_o, done_o, error_o, tready_s_o, checksum_o);
        end
        reset_n = 1'b1;
        @(posedge sys_clk); #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy got %b want 0", busy_o);
        end
    endtask

    task automatic test_full_load();
        bit t1, t2;
        int base;
        logic [39:0] got;
        for (int i = 0; i < NC; i++) coef[i] = 16'(i + 1);
        wr_q.delete();
        base = done_cnt;
        run_load(NC, NC - 1, 0, 1'b0, -1, t1);
        wait_done(base, t2);
        build_expected(N);
        checks++;
        if (t1 || t2) begin
            errors++;
            $display("FAIL full_timeout: got drive=%b done=%b want 0 0", t1, t2);
        end
        checks++;
        if (wr_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL full_count: got %0d want %0d", wr_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL full_wr[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        got = (wr_q.size() == 16) ? wr_q[15] : 'x;
        checks++;
        if (got !== 40'h0F_0020001F) begin
            errors++;
            $display("FAIL full_addr15: got %h want 0f0020001f", got);
        end
        got = (wr_q.size() > 1) ? wr_q[1] : 'x;
        checks++;
        if (got !== 40'h01_00040003) begin
            errors++;
            $display("FAIL full_addr1: got %h want 0100040003", got);
        end
        checks++;
        if (done_cnt !== base + 1) begin
            errors++;
            $display("FAIL full_done: got %0d pulses want 1", done_cnt - base);
        end
        checks++;
        if (error_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL full_status: got err=%b busy=%b want 0 0", error_o, busy_o);
        end
        checks++;
        if (checksum_o !== exp_sum(NC)) begin
            errors++;
            $display("FAIL full_checksum: got %h want %h", checksum_o, exp_sum(NC));
        end
    endtask

    task automatic test_early_tlast();
        bit t1, t2;
        int base;
        logic [39:0] got;
        for (int i = 0; i < NC; i++) coef[i] = 16'(i + 1);
        wr_q.delete();
        base = done_cnt;
        run_load(6, 5, 0, 1'b0, -1, t1);
        wait_done(base, t2);
        build_expected(1);
        checks++;
        if (t1 || t2) begin
            errors++;
            $display("FAIL early_timeout: got drive=%b done=%b want 0 0", t1, t2);
        end
        checks++;
        if (wr_q.size() != 2) begin
            errors++;
            $display("FAIL early_count: got %0d want 2", wr_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL early_wr[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        checks++;
        if (error_o !== 1'b1 || done_cnt !== base + 1) begin
            errors++;
            $display("FAIL early_status: got err=%b pulses=%0d want 1 1", error_o, done_cnt - base);
        end
        checks++;
        if (checksum_o !== exp_sum(6)) begin
            errors++;
            $display("FAIL early_checksum: got %h want %h", checksum_o, exp_sum(6));
        end
        tvalid = 1'b1;
        @(posedge sys_clk); #1;
        checks++;
        if (tready_s_o !== 1'b0) begin
            errors++;
            $display("FAIL early_tready_after: got %b want 0", tready_s_o);
        end
        tvalid = 1'b0;
    endtask

    task automatic test_missing_tlast();
        bit t1, t2;
        int base;
        logic [39:0] got;
        for (int i = 0; i < NC; i++) coef[i] = 16'($urandom);
        wr_q.delete();
        base = done_cnt;
        run_load(NC, -1, 0, 1'b0, -1, t1);
        wait_done(base, t2);
        build_expected(N);
        checks++;
        if (t1 || t2 || wr_q.size() != 16) begin
            errors++;
            $display("FAIL missing_count: got %0d writes tmo=%b%b want 16", wr_q.size(), t1, t2);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL missing_wr[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        checks++;
        if (error_o !== 1'b1 || done_cnt !== base + 1) begin
            errors++;
            $display("FAIL missing_status: got err=%b pulses=%0d want 1 1", error_o, done_cnt - base);
        end
    endtask

    task automatic test_backpressure_ce();
        bit t1, t2;
        int base;
        logic [39:0] got;
        for (int i = 0; i < NC; i++) coef[i] = 16'(i + 1);
        wr_q.delete();
        ce_viol = 0;
        base = done_cnt;
        run_load(NC, NC - 1, 1, 1'b1, -1, t1);
        wait_done(base, t2);
        build_expected(N);
        checks++;
        if (t1 || t2 || wr_q.size() != 16) begin
            errors++;
            $display("FAIL bp_count: got %0d writes tmo=%b%b want 16", wr_q.size(), t1, t2);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_wr[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
        checks++;
        if (ce_viol != 0) begin
            errors++;
            $display("FAIL bp_wr_while_ce0: got %0d want 0", ce_viol);
        end
        checks++;
        if (error_o !== 1'b0 || done_cnt !== base + 1) begin
            errors++;
            $display("FAIL bp_status: got err=%b pulses=%0d want 0 1", error_o, done_cnt - base);
        end
    endtask

    task automatic test_reset_midload();
        bit t1, t2;
        int base;
        logic [39:0] got;
        for (int i = 0; i < NC; i++) coef[i] = 16'(i + 1);
        wr_q.delete();
        base = done_cnt;
        run_load(3 * S, -1, 0, 1'b0, -1, t1);
        reset_n = 1'b0;
        @(posedge sys_clk); #1;
        reset_n = 1'b1;
        wr_q.delete();
        checks++;
        if ({tready_s_o, coeff_addr, coeff_wdata, coeff_wr, busy_o,
             done_o, error_o, checksum_o} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got addr=%h data=%h wr=%b busy=%b want all zero",
                     coeff_addr, coeff_wdata, coeff_wr, busy_o);
        end
        tvalid = 1'b1;
        repeat (10) @(posedge sys_clk);
        #1;
        tvalid = 1'b0;
        checks++;
        if (wr_q.size() != 0 || done_cnt != base || t1) begin
            errors++;
            $display("FAIL midreset_quiet: got writes=%0d pulses=%0d want 0 0", wr_q.size(), done_cnt - base);
        end
        run_load(NC, NC - 1, 0, 1'b0, -1, t1);
        wait_done(base, t2);
        build_expected(N);
        checks++;
        if (t1 || t2 || wr_q.size() != 16 || error_o !== 1'b0) begin
            errors++;
            $display("FAIL midreset_reload: got writes=%0d err=%b tmo=%b%b want 16 0", wr_q.size(), error_o, t1, t2);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 'x;
            checks++;
            if (got !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_wr[%0d]: got %h want %h", i, got, exp_q[i]);
            end
        end
    endtask

    task automatic test_start_while_busy();
        bit t1, t2;
        int base;
        bit seen;
        for (int i = 0; i < NC; i++) coef[i] = 16'($urandom);
        wr_q.delete();
        base = done_cnt;
        seen = 1'b0;
        run_load(NC, NC - 1, 0, 1'b0, 13, t1);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge sys_clk); #1;
            if (done_o) begin
                seen = 1'b1;
                start_i = 1'b1;
                @(posedge sys_clk); #1;
                start_i = 1'b0;
            end
        end
        checks++;
        if (!seen || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_at_done: got seen=%b busy=%b want 1 0", seen, busy_o);
        end
        wait_done(base, t2);
        checks++;
        if (t1 || wr_q.size() != 16 || done_cnt != base + 1 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL start_busy: got writes=%0d pulses=%0d busy=%b want 16 1 0",
                     wr_q.size(), done_cnt - base, busy_o);
        end
    endtask

    task automatic test_random();
        bit t1, t2;
        int base;
        int last;
        int rows;
        logic [39:0] got;
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < NC; i++) coef[i] = 16'($urandom);
            last = ($urandom_range(0, 1) == 1) ? NC - 1 : int'($urandom_range(0, NC - 2));
            rows = (last == NC - 1) ? N : last / S;
            wr_q.delete();
            base = done_cnt;
            run_load(last + 1, last, 2, 1'b0, -1, t1);
            wait_done(base, t2);
            build_expected(rows);
            checks++;
            if (t1 || t2 || wr_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_count: got %0d want %0d tlast@%0d", it, wr_q.size(), exp_q.size(), last);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                got = (i < wr_q.size()) ? wr_q[i] : 'x;
                checks++;
                if (got !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rand%0d_wr[%0d]: got %h want %h", it, i, got, exp_q[i]);
                end
            end
            checks++;
            if (error_o !== (last != NC - 1) || done_cnt != base + 1) begin
                errors++;
                $display("FAIL rand%0d_status: got err=%b pulses=%0d tlast@%0d", it, error_o, done_cnt - base, last);
            end
            checks++;
            if (checksum_o !== exp_sum(last + 1)) begin
                errors++;
                $display("FAIL rand%0d_checksum: got %h want %h", it, checksum_o, exp_sum(last + 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_early_tlast();
        test_missing_tlast();
        test_backpressure_ce();
        test_reset_midload();
        test_start_while_busy();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
